writeback_stage: RTL and testbench
==================================

// Module: writeback_stage
// PURPOSE
//  Final pipeline stage. Consumes the WB_* bundle that the execute stage produces and commits the instruction.
//  Commit covers GPR writes, the EFLAGS merge, the EIP/CS update and the data-cache store handshake.
//  It also closes the REPNE CMPS loop: decrements ECX and redirects fetch while the loop continues.
//  Sits between execute and the register file / dcache write port. Back-pressures execute via WB_STALL.
// PARAMETERS
//  FLAGS_RESET  32'h0000_0002  EFLAGS value after reset (bit1 reserved-one)
// PORTS
//  CLK               in   1   clock
//  RST               in   1   reset, synchronous, active-high
//  IN_V              in   1   execute bundle valid (execute's WB_V)
//  IN_CEIP           in   32  EIP of the instruction itself (REPNE redirect target)
//  IN_NEIP / IN_NCS  in   32/16  next EIP / CS to commit
//  IN_RESULT         in   32  ALU32 result
//  IN_FLAGS          in   32  ALU flags
//  IN_CMPS_POINTER   in   32  updated string pointer
//  IN_COUNT          in   32  ECX value entering this uop
//  IN_DR1/IN_DR2     in   3   destination GPR ids (DR2 = pointer register)
//  IN_DATASIZE       in   2   00 byte, 01 word, 10 dword
//  IN_LD_GPR1/IN_LD_GPR2/IN_LD_FLAGS  in 1  write enables
//  IN_FLAGS_AFFECTED in   7   {OF,DF,SF,ZF,AF,PF,CF} merge mask
//  IN_MEM_WR         in   1   uop stores IN_RESULT to dcache
//  IN_IS_REPNE       in   1   uop is the compare uop of REPNE CMPS
//  WB_STALL          out  1   hold execute; input not captured this cycle
//  DC_WR_REQ         out  1   dcache store request
//  DC_WR_ACK         in   1   dcache accepted the store
//  GPR_WE1/GPR_WE2/GPR_WE3  out 1   port1 result, port2 pointer, port3 ECX
//  GPR_ADDR1/2       out  3   GPR ids (port3 fixed to ECX = 3'd1)
//  GPR_DATA1/2/3     out  32  write data
//  GPR_SIZE1         out  2   datasize for port1 (ports 2/3 always dword)
//  FLAGS             out  32  architectural EFLAGS register
//  COMMIT_V          out  1   one instruction committed this cycle
//  EIP_OUT / CS_OUT  out  32/16  committed EIP / CS (registered)
//  REDIRECT / REDIRECT_EIP  out 1/32  restart fetch at REDIRECT_EIP
// BEHAVIOUR
//  - Input latch: captures all IN_* at rising CLK when !WB_STALL. Latch valid = IN_V & !REDIRECT.
//    The younger uop arriving in the redirect cycle is squashed.
//  - Latency: capture at edge N; commit strobes are combinational from the latch during cycle N..N+1.
//    The register file and FLAGS update at edge N+1.
//  - FSM S_RUN / S_MEMWAIT:
//    - S_RUN, latch valid, !IN_MEM_WR: commit this cycle, WB_STALL=0.
//    - S_RUN, valid, IN_MEM_WR: DC_WR_REQ=1. DC_WR_ACK same cycle -> commit, stay S_RUN.
//      Otherwise WB_STALL=1, no commit, go S_MEMWAIT.
//    - S_MEMWAIT: DC_WR_REQ=1, WB_STALL=1. On DC_WR_ACK -> commit, WB_STALL=0, go S_RUN.
//  - Commit cycle: COMMIT_V=1.
//    - GPR_WE1 = LD_GPR1; GPR_DATA1 = RESULT; GPR_SIZE1 = DATASIZE.
//    - GPR_WE2 = LD_GPR2 with CMPS_POINTER.
//    - FLAGS <= LD_FLAGS ? (FLAGS & ~m) | (IN_FLAGS & m) : FLAGS, where m maps mask bits to
//      EFLAGS bits 0,2,4,6,7,10,11.
//    - EIP_OUT/CS_OUT <= NEIP/NCS unless REDIRECT.
//  - All write strobes are 0 outside commit cycles.
//  - REPNE (macro on), at commit of an IS_REPNE uop:
//    - COUNT==0: no compare-side writes (WE1/WE2/flags suppressed), no WE3, no redirect; EIP commits NEIP.
//    - Else GPR_WE3=1, GPR_DATA3=COUNT-1 (32-bit wrap).
//    - REDIRECT=1, REDIRECT_EIP=CEIP iff (COUNT-1)!=0 and merged ZF==0. EIP_OUT/CS_OUT hold.
//    - Otherwise no redirect, NEIP commits.
//  - Reset (any state, incl. S_MEMWAIT):
//    - latch valid 0, S_RUN, FLAGS=FLAGS_RESET, EIP_OUT=0, CS_OUT=0.
//    - All strobes, REDIRECT, DC_WR_REQ, WB_STALL = 0. A pending store is abandoned.
// CONFIGURATION
//  WB_REPNE_EN defined: REPNE handling above; GPR port3 active.
//  Undefined: IN_IS_REPNE ignored; GPR_WE3=0, REDIRECT=0; instruction always commits NEIP.
// TESTING
//  1. ADD dword, DR1=3, LD_GPR1, LD_FLAGS, mask 7'h7F, IN_FLAGS=32'h8C5:
//     -> next cycle GPR_WE1, ADDR1=3, FLAGS=32'h8C7, COMMIT_V=1.
//  2. Store, DC_WR_ACK held low 3 cycles:
//     -> WB_STALL=1 and DC_WR_REQ=1 for 3 cycles, no COMMIT_V; commit on ack cycle, input captured next edge.
//  3. REPNE CMPS, COUNT=5, ZF result 0:
//     -> GPR_DATA3=4, REDIRECT=1, REDIRECT_EIP=CEIP; following IN_V uop squashed.
//  4. REPNE CMPS, COUNT=1 -> DATA3=0, no redirect, EIP_OUT=NEIP.
//     COUNT=0 -> no GPR/flag writes, EIP_OUT=NEIP.
//  5. RST asserted while in S_MEMWAIT -> next cycle DC_WR_REQ=0, WB_STALL=0, FLAGS=32'h2, no commit.
//  6. Build without WB_REPNE_EN, repeat test 3 -> REDIRECT=0, GPR_WE3=0, EIP_OUT=NEIP.

Source files
------------

// File: rtl/writeback_stage.sv
// Writeback stage: commits the execute bundle to the GPRs, EFLAGS, EIP/CS and the dcache store port.
// Optional REPNE CMPS loop control (ECX decrement, fetch redirect) is built when WB_REPNE_EN is defined.
`timescale 1ns/1ps
module writeback_stage #(
  parameter logic [31:0] FLAGS_RESET = 32'h0000_0002
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IN_V,
  input  logic [31:0] IN_CEIP,
  input  logic [31:0] IN_NEIP,
  input  logic [15:0] IN_NCS,
  input  logic [31:0] IN_RESULT,
  input  logic [31:0] IN_FLAGS,
  input  logic [31:0] IN_CMPS_POINTER,
  input  logic [31:0] IN_COUNT,
  input  logic [2:0]  IN_DR1,
  input  logic [2:0]  IN_DR2,
  input  logic [1:0]  IN_DATASIZE,
  input  logic        IN_LD_GPR1,
  input  logic        IN_LD_GPR2,
  input  logic        IN_LD_FLAGS,
  input  logic [6:0]  IN_FLAGS_AFFECTED,
  input  logic        IN_MEM_WR,
  input  logic        IN_IS_REPNE,
  output logic        WB_STALL,
  output logic        DC_WR_REQ,
  input  logic        DC_WR_ACK,
  output logic        GPR_WE1,
  output logic        GPR_WE2,
  output logic        GPR_WE3,
  output logic [2:0]  GPR_ADDR1,
  output logic [2:0]  GPR_ADDR2,
  output logic [31:0] GPR_DATA1,
  output logic [31:0] GPR_DATA2,
  output logic [31:0] GPR_DATA3,
  output logic [1:0]  GPR_SIZE1,
  output logic [31:0] FLAGS,
  output logic        COMMIT_V,
  output logic [31:0] EIP_OUT,
  output logic [15:0] CS_OUT,
  output logic        REDIRECT,
  output logic [31:0] REDIRECT_EIP
);

  typedef enum logic {S_RUN, S_MEMWAIT} state_t;

  state_t      state_q;
  logic        v_q;
  logic [31:0] flags_q, flags_d;
  logic [31:0] eip_q, eip_d;
  logic [15:0] cs_q, cs_d;

  logic [31:0] ceip_q, neip_q, result_q, fin_q, ptr_q, count_q;
  logic [15:0] ncs_q;
  logic [2:0]  dr1_q, dr2_q;
  logic [1:0]  size_q;
  logic        ld1_q, ld2_q, ldf_q, memwr_q;
  logic [6:0]  mask_q;

  logic        mem_pend, commit, suppress;
  logic [31:0] flag_mask, flags_new;

`ifdef WB_REPNE_EN
  logic        repne_q;
  logic        rep_zero;
  logic [31:0] count_dec;

  always_ff @(posedge CLK) begin
    if (!WB_STALL) repne_q <= IN_IS_REPNE;
  end
`else
  logic unused_repne;
  assign unused_repne = IN_IS_REPNE;
`endif

  // Bundle latch; held while a store waits for the dcache.
  always_ff @(posedge CLK) begin
    if (!WB_STALL) begin
      ceip_q   <= IN_CEIP;
      neip_q   <= IN_NEIP;
      ncs_q    <= IN_NCS;
      result_q <= IN_RESULT;
      fin_q    <= IN_FLAGS;
      ptr_q    <= IN_CMPS_POINTER;
      count_q  <= IN_COUNT;
      dr1_q    <= IN_DR1;
      dr2_q    <= IN_DR2;
      size_q   <= IN_DATASIZE;
      ld1_q    <= IN_LD_GPR1;
      ld2_q    <= IN_LD_GPR2;
      ldf_q    <= IN_LD_FLAGS;
      mask_q   <= IN_FLAGS_AFFECTED;
      memwr_q  <= IN_MEM_WR;
    end
  end

  // Commit decode, EFLAGS merge and loop control.
  always_comb begin
    mem_pend     = v_q & memwr_q;
    commit       = v_q & (~memwr_q | DC_WR_ACK);
    DC_WR_REQ    = mem_pend | (state_q == S_MEMWAIT);
    WB_STALL     = DC_WR_REQ & ~DC_WR_ACK;
    COMMIT_V     = commit;
    // {OF,DF,SF,ZF,AF,PF,CF} -> EFLAGS bits 11,10,7,6,4,2,0
    flag_mask    = {20'd0, mask_q[6], mask_q[5], 2'b00, mask_q[4], mask_q[3], 1'b0,
                    mask_q[2], 1'b0, mask_q[1], 1'b0, mask_q[0]};
    flags_new    = ldf_q ? ((flags_q & ~flag_mask) | (fin_q & flag_mask)) : flags_q;
    suppress     = 1'b0;
    GPR_WE3      = 1'b0;
    REDIRECT     = 1'b0;
`ifdef WB_REPNE_EN
    rep_zero     = repne_q & (count_q == 32'd0);
    count_dec    = count_q - 32'd1;
    suppress     = rep_zero;
    GPR_WE3      = commit & repne_q & ~rep_zero;
    REDIRECT     = commit & repne_q & ~rep_zero & (count_dec != 32'd0) & ~flags_new[6];
`endif
    GPR_WE1      = commit & ld1_q & ~suppress;
    GPR_WE2      = commit & ld2_q & ~suppress;
    GPR_ADDR1    = dr1_q;
    GPR_ADDR2    = dr2_q;
    GPR_DATA1    = result_q;
    GPR_DATA2    = ptr_q;
    GPR_DATA3    = count_q - 32'd1;
    GPR_SIZE1    = size_q;
    REDIRECT_EIP = ceip_q;
    flags_d      = (commit & ~suppress) ? flags_new : flags_q;
    eip_d        = (commit & ~REDIRECT) ? neip_q : eip_q;
    cs_d         = (commit & ~REDIRECT) ? ncs_q : cs_q;
  end

  // Control state, architectural registers and store-wait FSM.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_RUN;
      v_q     <= 1'b0;
      flags_q <= FLAGS_RESET;
      eip_q   <= 32'd0;
      cs_q    <= 16'd0;
    end else begin
      flags_q <= flags_d;
      eip_q   <= eip_d;
      cs_q    <= cs_d;
      if (!WB_STALL) v_q <= IN_V & ~REDIRECT;
      case (state_q)
        S_RUN:     if (mem_pend && !DC_WR_ACK) state_q <= S_MEMWAIT;
        S_MEMWAIT: if (DC_WR_ACK) state_q <= S_RUN;
        default:   state_q <= S_RUN;
      endcase
    end
  end

  assign FLAGS   = flags_q;
  assign EIP_OUT = eip_q;
  assign CS_OUT  = cs_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: directed scenarios plus randomized uops against an
// architectural model of commit; follows WB_REPNE_EN the same way the design does.
`timescale 1ns/1ps
module tb_writeback_stage;

  localparam logic [31:0] FLAGS_RESET = 32'h0000_0002;
`ifdef WB_REPNE_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] ceip, neip;
    logic [15:0] ncs;
    logic [31:0] result, flags, ptr, count;
    logic [2:0]  dr1, dr2;
    logic [1:0]  size;
    logic        ld1, ld2, ldf;
    logic [6:0]  mask;
    logic        memwr, repne;
  } uop_t;

  typedef struct packed {
    logic        we1;
    logic [2:0]  addr1;
    logic [31:0] data1;
    logic [1:0]  size1;
    logic        we2;
    logic [2:0]  addr2;
    logic [31:0] data2;
    logic        we3;
    logic [31:0] data3;
    logic        redir;
    logic [31:0] reip, pre_flags, pre_eip;
    logic [15:0] pre_cs;
  } exp_t;

  typedef struct packed {
    logic        stall, req, commit, redirect, we3;
    logic [31:0] flags, eip;
  } smp_t;

  logic CLK = 1'b0;
  logic RST;
  logic IN_V, IN_LD_GPR1, IN_LD_GPR2, IN_LD_FLAGS, IN_MEM_WR, IN_IS_REPNE, DC_WR_ACK;
  logic [31:0] IN_CEIP, IN_NEIP, IN_RESULT, IN_FLAGS, IN_CMPS_POINTER, IN_COUNT;
  logic [15:0] IN_NCS;
  logic [2:0]  IN_DR1, IN_DR2;
  logic [1:0]  IN_DATASIZE;
  logic [6:0]  IN_FLAGS_AFFECTED;
  logic WB_STALL, DC_WR_REQ, GPR_WE1, GPR_WE2, GPR_WE3, COMMIT_V, REDIRECT;
  logic [2:0]  GPR_ADDR1, GPR_ADDR2;
  logic [31:0] GPR_DATA1, GPR_DATA2, GPR_DATA3, FLAGS, EIP_OUT, REDIRECT_EIP;
  logic [1:0]  GPR_SIZE1;
  logic [15:0] CS_OUT;

  always #5 CLK = ~CLK;

  writeback_stage #(.FLAGS_RESET(FLAGS_RESET)) dut (
    .CLK(CLK), .RST(RST), .IN_V(IN_V), .IN_CEIP(IN_CEIP), .IN_NEIP(IN_NEIP), .IN_NCS(IN_NCS),
    .IN_RESULT(IN_RESULT), .IN_FLAGS(IN_FLAGS), .IN_CMPS_POINTER(IN_CMPS_POINTER),
    .IN_COUNT(IN_COUNT), .IN_DR1(IN_DR1), .IN_DR2(IN_DR2), .IN_DATASIZE(IN_DATASIZE),
    .IN_LD_GPR1(IN_LD_GPR1), .IN_LD_GPR2(IN_LD_GPR2), .IN_LD_FLAGS(IN_LD_FLAGS),
    .IN_FLAGS_AFFECTED(IN_FLAGS_AFFECTED), .IN_MEM_WR(IN_MEM_WR), .IN_IS_REPNE(IN_IS_REPNE),
    .WB_STALL(WB_STALL), .DC_WR_REQ(DC_WR_REQ), .DC_WR_ACK(DC_WR_ACK),
    .GPR_WE1(GPR_WE1), .GPR_WE2(GPR_WE2), .GPR_WE3(GPR_WE3),
    .GPR_ADDR1(GPR_ADDR1), .GPR_ADDR2(GPR_ADDR2),
    .GPR_DATA1(GPR_DATA1), .GPR_DATA2(GPR_DATA2), .GPR_DATA3(GPR_DATA3),
    .GPR_SIZE1(GPR_SIZE1), .FLAGS(FLAGS), .COMMIT_V(COMMIT_V), .EIP_OUT(EIP_OUT),
    .CS_OUT(CS_OUT), .REDIRECT(REDIRECT), .REDIRECT_EIP(REDIRECT_EIP)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Architectural model: state as it will be once every accepted uop has committed.
  logic [31:0] m_flags, m_eip;
  logic [15:0] m_cs;
  bit          squash_next;
  exp_t        sb[$];

  function automatic logic [31:0] expand_mask(input logic [6:0] msk);
    int pos [7];
    logic [31:0] r;
    pos = '{0, 2, 4, 6, 7, 10, 11};
    r = 32'd0;
    for (int i = 0; i < 7; i++) r[pos[i]] = msk[i];
    return r;
  endfunction

  task automatic model_reset();
    sb.delete();
    m_flags = FLAGS_RESET;
    m_eip = 32'd0;
    m_cs = 16'd0;
    squash_next = 1'b0;
  endtask

  task automatic model_capture(input bit v, input uop_t u);
    exp_t e;
    logic [31:0] mk;
    bit rep;
    if (squash_next) begin
      squash_next = 1'b0;
      return;
    end
    if (!v) return;
    e = '0;
    e.pre_flags = m_flags;
    e.pre_eip = m_eip;
    e.pre_cs = m_cs;
    rep = REP_EN && u.repne;
    if (rep && u.count == 32'd0) begin
      m_eip = u.neip;
      m_cs = u.ncs;
    end else begin
      e.we1 = u.ld1; e.addr1 = u.dr1; e.data1 = u.result; e.size1 = u.size;
      e.we2 = u.ld2; e.addr2 = u.dr2; e.data2 = u.ptr;
      mk = expand_mask(u.mask);
      if (u.ldf) m_flags = (m_flags & ~mk) | (u.flags & mk);
      if (rep) begin
        e.we3 = 1'b1;
        e.data3 = u.count - 32'd1;
      end
      if (rep && u.count != 32'd1 && !m_flags[6]) begin
        e.redir = 1'b1;
        e.reip = u.ceip;
        squash_next = 1'b1;
      end else begin
        m_eip = u.neip;
        m_cs = u.ncs;
      end
    end
    sb.push_back(e);
  endtask

  // Monitor: pops one expected commit per COMMIT_V, otherwise requires quiet strobes.
  exp_t me;
  always @(negedge CLK) begin
    if (RST === 1'b0) begin
      if (COMMIT_V) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_commit: got COMMIT_V=1, expected no pending uop");
        end else begin
          me = sb.pop_front();
          check("we1", 32'(GPR_WE1), 32'(me.we1));
          if (me.we1) begin
            check("addr1", 32'(GPR_ADDR1), 32'(me.addr1));
            check("data1", GPR_DATA1, me.data1);
            check("size1", 32'(GPR_SIZE1), 32'(me.size1));
          end
          check("we2", 32'(GPR_WE2), 32'(me.we2));
          if (me.we2) begin
            check("addr2", 32'(GPR_ADDR2), 32'(me.addr2));
            check("data2", GPR_DATA2, me.data2);
          end
          check("we3", 32'(GPR_WE3), 32'(me.we3));
          if (me.we3) check("data3", GPR_DATA3, me.data3);
          check("redirect", 32'(REDIRECT), 32'(me.redir));
          if (me.redir) check("redirect_eip", REDIRECT_EIP, me.reip);
          check("flags_before", FLAGS, me.pre_flags);
          check("eip_before", EIP_OUT, me.pre_eip);
          check("cs_before", 32'(CS_OUT), 32'(me.pre_cs));
        end
      end else begin
        check("idle_we", 32'({GPR_WE1, GPR_WE2, GPR_WE3}), 32'd0);
        check("idle_redirect", 32'(REDIRECT), 32'd0);
      end
    end
  end

  task automatic drive(input bit v, input uop_t u, input bit ack, output smp_t s);
    IN_V = v; IN_CEIP = u.ceip; IN_NEIP = u.neip; IN_NCS = u.ncs; IN_RESULT = u.result;
    IN_FLAGS = u.flags; IN_CMPS_POINTER = u.ptr; IN_COUNT = u.count; IN_DR1 = u.dr1;
    IN_DR2 = u.dr2; IN_DATASIZE = u.size; IN_LD_GPR1 = u.ld1; IN_LD_GPR2 = u.ld2;
    IN_LD_FLAGS = u.ldf; IN_FLAGS_AFFECTED = u.mask; IN_MEM_WR = u.memwr;
    IN_IS_REPNE = u.repne; DC_WR_ACK = ack;
    @(negedge CLK);
    s = '{WB_STALL, DC_WR_REQ, COMMIT_V, REDIRECT, GPR_WE3, FLAGS, EIP_OUT};
    if (!s.stall) model_capture(v, u);
    @(posedge CLK);
    #1;
  endtask

  // Present u until accepted, with a random dcache ack each cycle.
  task automatic send(input uop_t u);
    smp_t s;
    int n;
    n = 0;
    do begin
      drive(1'b1, u, 1'($urandom_range(1, 0)), s);
      n++;
    end while (s.stall && n < 64);
    if (s.stall) check("send_timeout", 32'(s.stall), 32'd0);
  endtask

  function automatic uop_t rand_uop();
    uop_t u;
    u.ceip = $urandom; u.neip = $urandom; u.ncs = 16'($urandom);
    u.result = $urandom; u.flags = $urandom; u.ptr = $urandom;
    case ($urandom_range(3, 0))
      0: u.count = 32'd0;
      1: u.count = 32'd1;
      2: u.count = 32'd2;
      default: u.count = $urandom;
    endcase
    u.dr1 = 3'($urandom); u.dr2 = 3'($urandom); u.size = 2'($urandom_range(2, 0));
    u.ld1 = 1'($urandom); u.ld2 = 1'($urandom); u.ldf = 1'($urandom);
    u.mask = 7'($urandom);
    u.memwr = ($urandom_range(3, 0) == 0);
    u.repne = ($urandom_range(2, 0) == 0);
    return u;
  endfunction

  uop_t bub, u, y;
  smp_t s;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bub = '0;
    RST = 1'b1;
    IN_V = 0; IN_CEIP = 0; IN_NEIP = 0; IN_NCS = 0; IN_RESULT = 0; IN_FLAGS = 0;
    IN_CMPS_POINTER = 0; IN_COUNT = 0; IN_DR1 = 0; IN_DR2 = 0; IN_DATASIZE = 0;
    IN_LD_GPR1 = 0; IN_LD_GPR2 = 0; IN_LD_FLAGS = 0; IN_FLAGS_AFFECTED = 0;
    IN_MEM_WR = 0; IN_IS_REPNE = 0; DC_WR_ACK = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_flags", FLAGS, FLAGS_RESET);
    check("rst_eip", EIP_OUT, 32'd0);
    check("rst_cs", 32'(CS_OUT), 32'd0);
    check("rst_strobes", 32'({COMMIT_V, WB_STALL, DC_WR_REQ, REDIRECT}), 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;

    // ADD dword into EBX, all flags merged
    u = bub;
    u.dr1 = 3'd3; u.ld1 = 1'b1; u.ldf = 1'b1; u.mask = 7'h7F; u.flags = 32'h8C5;
    u.result = 32'h1234_5678; u.size = 2'b10; u.neip = 32'h10; u.ncs = 16'h8;
    drive(1'b1, u, 1'b0, s);
    drive(1'b0, bub, 1'b0, s);
    check("t1_commit", 32'(s.commit), 32'd1);
    drive(1'b0, bub, 1'b0, s);
    check("t1_flags", s.flags, 32'h8C7);

    // Store with the ack held off for three cycles
    u = bub;
    u.memwr = 1'b1; u.result = 32'hCAFE_F00D; u.neip = 32'h20; u.ncs = 16'h8;
    drive(1'b1, u, 1'b0, s);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, bub, 1'b0, s);
      check("t2_wait", 32'({s.stall, s.req, s.commit}), 32'b110);
    end
    y = bub;
    y.ld1 = 1'b1; y.dr1 = 3'd2; y.result = 32'h55; y.neip = 32'h24; y.ncs = 16'h8;
    drive(1'b1, y, 1'b1, s);
    check("t2_ack", 32'({s.stall, s.req, s.commit}), 32'b011);
    drive(1'b0, bub, 1'b0, s);
    check("t2_next_commit", 32'(s.commit), 32'd1);

    // REPNE CMPS, ECX=5, compare leaves ZF clear; younger uop behind it
    u = bub;
    u.repne = 1'b1; u.count = 32'd5; u.ldf = 1'b1; u.mask = 7'h08; u.flags = 32'h0;
    u.ld2 = 1'b1; u.dr2 = 3'd7; u.ptr = 32'h2000; u.ceip = 32'h100; u.neip = 32'h102;
    u.ncs = 16'h8;
    drive(1'b1, u, 1'b0, s);
    y = bub;
    y.ld1 = 1'b1; y.dr1 = 3'd0; y.result = 32'hDEAD; y.neip = 32'h104; y.ncs = 16'h8;
    drive(1'b1, y, 1'b0, s);
    check("t3_redirect", 32'(s.redirect), 32'(REP_EN));
    check("t3_we3", 32'(s.we3), 32'(REP_EN));
    drive(1'b0, bub, 1'b0, s);
    drive(1'b0, bub, 1'b0, s);
    check("t3_eip", s.eip, REP_EN ? 32'h24 : 32'h104);

    // REPNE CMPS, ECX=1 then ECX=0
    u.count = 32'd1; u.neip = 32'h202;
    drive(1'b1, u, 1'b0, s);
    drive(1'b0, bub, 1'b0, s);
    check("t4a_redirect", 32'(s.redirect), 32'd0);
    drive(1'b0, bub, 1'b0, s);
    check("t4a_eip", s.eip, 32'h202);
    u.count = 32'd0; u.neip = 32'h302; u.ld1 = 1'b1; u.ldf = 1'b1; u.mask = 7'h7F;
    u.flags = 32'hFFF;
    drive(1'b1, u, 1'b0, s);
    drive(1'b0, bub, 1'b0, s);
    drive(1'b0, bub, 1'b0, s);
    check("t4b_eip", s.eip, 32'h302);
    check("t4b_flags", s.flags, m_flags);

    // Reset while waiting on a store
    u = bub;
    u.memwr = 1'b1; u.neip = 32'h400;
    drive(1'b1, u, 1'b0, s);
    drive(1'b0, bub, 1'b0, s);
    check("t5_in_wait", 32'({s.stall, s.req}), 32'b11);
    RST = 1'b1; IN_V = 1'b0; DC_WR_ACK = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    model_reset();
    drive(1'b0, bub, 1'b0, s);
    check("t5_after", 32'({s.stall, s.req, s.commit}), 32'd0);
    check("t5_flags", s.flags, 32'h2);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3, 0) == 0) drive(1'b0, bub, 1'($urandom_range(1, 0)), s);
      else send(rand_uop());
    end
    for (int i = 0; i < 4; i++) drive(1'b0, bub, 1'b1, s);
    check("drain_sb", 32'(sb.size()), 32'd0);
    check("final_flags", FLAGS, m_flags);
    check("final_eip", EIP_OUT, m_eip);
    check("final_cs", 32'(CS_OUT), 32'(m_cs));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
